// File: rtl/dvb_s2_cfg_pkg.sv
// Shared types and constants for the DVB-S/S2 configuration sequencer.
// Mode-bundle layout, reset defaults and FSM state encoding.
package dvb_s2_cfg_pkg;

    localparam int MODE_W = 17;

    localparam int MOD_LSB = 0;
    localparam int MOD_W = 2;
    localparam int LDPC_LSB = 2;
    localparam int LDPC_W = 4;
    localparam int FRAME_BIT = 6;
    localparam int PILOT_BIT = 7;
    localparam int SRRC_LSB = 8;
    localparam int SRRC_W = 2;
    localparam int CONV_LSB = 10;
    localparam int CONV_W = 3;
    localparam int DVBS_BIT = 13;
    localparam int TS_SRC_LSB = 14;
    localparam int TS_SRC_W = 2;
    localparam int FREQ_INV_BIT = 16;

    localparam logic [MODE_W-1:0] MODE_DEFAULT = 17'h06218;
    localparam logic [31:0] BAUD_DEFAULT = 32'd2500;
    localparam logic [31:0] FREQ_DEFAULT = 32'd12500;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [31:0] baud;
        logic [31:0] freq;
    } cfg_t;

    localparam cfg_t CFG_DEFAULT = '{
        mode: MODE_DEFAULT,
        baud: BAUD_DEFAULT,
        freq: FREQ_DEFAULT
    };

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BND,
        RST_HOLD,
        WAIT_LOCK
    } state_t;

endpackage

// File: rtl/dvb_s2_cfg_sequencer_if.sv
// Bus between host/datapath side and the configuration sequencer.
// master drives requests and strobes; slave is the sequencer.
interface dvb_s2_cfg_sequencer_if;
    logic [16:0] cfg_mode_in;
    logic [31:0] cfg_baud_in;
    logic [31:0] cfg_freq_in;
    logic apply_req;
    logic force_req;
    logic ts_head;
    logic symbol_oe;
    logic err_clr;
    logic [16:0] act_mode;
    logic [31:0] act_baud;
    logic [31:0] act_freq;
    logic datapath_rst_n;
    logic busy;
    logic locked;
    logic done;
    logic fail;
    logic err_bnd_to;
    logic err_lock_to;

    modport master (
        output cfg_mode_in, cfg_baud_in, cfg_freq_in,
        output apply_req, force_req, ts_head, symbol_oe, err_clr,
        input act_mode, act_baud, act_freq, datapath_rst_n,
        input busy, locked, done, fail, err_bnd_to, err_lock_to
    );

    modport slave (
        input cfg_mode_in, cfg_baud_in, cfg_freq_in,
        input apply_req, force_req, ts_head, symbol_oe, err_clr,
        output act_mode, act_baud, act_freq, datapath_rst_n,
        output busy, locked, done, fail, err_bnd_to, err_lock_to
    );
endinterface

// File: rtl/dvb_s2_cfg_sequencer.sv
// Sequences every modulator configuration change: boundary wait,
// atomic apply under datapath reset, then symbol-output lock check.
import dvb_s2_cfg_pkg::*;

module dvb_s2_cfg_sequencer #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_COUNT = 64,
    parameter int WDOG_CYCLES = 1048576,
    parameter int CNT_W = 21
) (
    input logic clk,
    input logic rst_n,
    dvb_s2_cfg_sequencer_if.slave bus
);

    localparam int PCNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [PCNT_W-1:0] LOCK_LAST = PCNT_W'(LOCK_COUNT - 1);

    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [PCNT_W-1:0] pcnt;
    cfg_t cfg_in, stg, act;
    logic pending, pend_force;
    logic drst_n, locked, done, fail, err_bnd, err_lock;
    logic launch, force_now, bnd_to, lock_hit, lock_to;
    logic entry, rst_entry;

    assign cfg_in = '{
        mode: bus.cfg_mode_in,
        baud: bus.cfg_baud_in,
        freq: bus.cfg_freq_in
    };
    assign force_now = pend_force | (bus.apply_req & bus.force_req);
    assign entry = (state_nx != state);
    assign rst_entry = entry && (state_nx == RST_HOLD);

    always_comb begin
        state_nx = state;
        launch = 1'b0;
        bnd_to = 1'b0;
        lock_hit = 1'b0;
        lock_to = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.apply_req || pending) begin
                    launch = 1'b1;
                    state_nx = force_now ? RST_HOLD : WAIT_BND;
                end
            end
            WAIT_BND: begin
                if (bus.ts_head) begin
                    state_nx = RST_HOLD;
                end else if (cnt == WDOG_LAST) begin
                    bnd_to = 1'b1;
                    state_nx = RST_HOLD;
                end
            end
            RST_HOLD: begin
                if (cnt == HOLD_LAST) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (bus.symbol_oe && pcnt == LOCK_LAST) begin
                    lock_hit = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == WDOG_LAST) begin
                    lock_to = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RST_HOLD;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            pcnt <= '0;
            stg <= CFG_DEFAULT;
            act <= CFG_DEFAULT;
            pending <= 1'b0;
            pend_force <= 1'b0;
            drst_n <= 1'b0;
            locked <= 1'b0;
            done <= 1'b0;
            fail <= 1'b0;
            err_bnd <= 1'b0;
            err_lock <= 1'b0;
        end else begin
            cnt <= entry ? '0 : cnt + CNT_W'(1);
            if (entry) pcnt <= '0;
            else if (bus.symbol_oe) pcnt <= pcnt + PCNT_W'(1);

            // One-deep request slot; cfg itself is re-sampled at launch
            if (launch) begin
                stg <= cfg_in;
                pending <= 1'b0;
                pend_force <= 1'b0;
            end else if (bus.apply_req && state != IDLE) begin
                pending <= 1'b1;
                pend_force <= pend_force | bus.force_req;
            end

            if (rst_entry) begin
                act <= (state == IDLE) ? cfg_in : stg;
                drst_n <= 1'b0;
                locked <= 1'b0;
            end else if (state == RST_HOLD && state_nx == WAIT_LOCK) begin
                drst_n <= 1'b1;
            end

            if (lock_hit) locked <= 1'b1;
            else if (lock_to) locked <= 1'b0;
            done <= lock_hit;
            fail <= lock_to;

            err_bnd <= bnd_to | (err_bnd & ~bus.err_clr);
            err_lock <= lock_to | (err_lock & ~bus.err_clr);
        end
    end

    assign bus.act_mode = act.mode;
    assign bus.act_baud = act.baud;
    assign bus.act_freq = act.freq;
    assign bus.datapath_rst_n = drst_n;
    assign bus.busy = (state != IDLE);
    assign bus.locked = locked;
    assign bus.done = done;
    assign bus.fail = fail;
    assign bus.err_bnd_to = err_bnd;
    assign bus.err_lock_to = err_lock;

endmodule

// File: tb/tb_dvb_s2_cfg_sequencer.sv
// Directed/randomized bench for dvb_s2_cfg_sequencer.
// Expected cfg and timing come from a small model kept in the bench.
module tb_dvb_s2_cfg_sequencer;

    localparam int HOLD = 16;
    localparam int LOCKN = 64;
    localparam int WDOG = 256;
    localparam logic [16:0] DEF_MODE = 17'h06218;
    localparam logic [31:0] DEF_BAUD = 32'd2500;
    localparam logic [31:0] DEF_FREQ = 32'd12500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int n;
    int busy_cnt;

    // c_* is what the host drives now, m_* is what act_* must show
    logic [16:0] c_mode, m_mode;
    logic [31:0] c_baud, c_freq, m_baud, m_freq;

    dvb_s2_cfg_sequencer_if bus ();

    dvb_s2_cfg_sequencer #(
        .RST_HOLD_CYCLES(HOLD),
        .LOCK_COUNT(LOCKN),
        .WDOG_CYCLES(WDOG),
        .CNT_W(21)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg();
        bus.cfg_mode_in = c_mode;
        bus.cfg_baud_in = c_baud;
        bus.cfg_freq_in = c_freq;
    endtask

    task automatic new_cfg();
        c_mode = 17'($urandom);
        c_baud = $urandom;
        c_freq = $urandom;
        drive_cfg();
    endtask

    task automatic take_model();
        m_mode = c_mode;
        m_baud = c_baud;
        m_freq = c_freq;
    endtask

    task automatic apply(input logic frc);
        bus.apply_req = 1'b1;
        bus.force_req = frc;
        tick();
        bus.apply_req = 1'b0;
        bus.force_req = 1'b0;
    endtask

    task automatic chk_act(input string tag);
        chk({tag, "_mode"}, 64'(bus.act_mode), 64'(m_mode));
        chk({tag, "_baud"}, 64'(bus.act_baud), 64'(m_baud));
        chk({tag, "_freq"}, 64'(bus.act_freq), 64'(m_freq));
    endtask

    task automatic wait_drst(input logic lvl, input int lim);
        n = 0;
        while (bus.datapath_rst_n !== lvl && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic feed_lock(input string tag);
        int early = 0;
        for (int p = 1; p <= LOCKN; p++) begin
            int gap = $urandom_range(0, 2);
            repeat (gap) begin
                tick();
                if (bus.done || bus.fail || !bus.busy) early++;
            end
            bus.symbol_oe = 1'b1;
            tick();
            bus.symbol_oe = 1'b0;
            if (p < LOCKN && (bus.done || bus.fail || !bus.busy)) early++;
        end
        chk({tag, "_early"}, 64'(early), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd1);
        chk({tag, "_locked"}, 64'(bus.locked), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_nofail"}, 64'(bus.fail), 64'd0);
        tick();
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.apply_req = 1'b0;
        bus.force_req = 1'b0;
        bus.ts_head = 1'b0;
        bus.symbol_oe = 1'b0;
        bus.err_clr = 1'b0;
        c_mode = '0;
        c_baud = '0;
        c_freq = '0;
        drive_cfg();
        m_mode = DEF_MODE;
        m_baud = DEF_BAUD;
        m_freq = DEF_FREQ;

        repeat (3) tick();
        chk_act("rst");
        chk("rst_drst", 64'(bus.datapath_rst_n), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd1);
        chk("rst_locked", 64'(bus.locked), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_fail", 64'(bus.fail), 64'd0);
        chk("rst_errs", 64'({bus.err_bnd_to, bus.err_lock_to}), 64'd0);

        // power-up pass
        rst_n = 1'b1;
        wait_drst(1'b1, 100);
        chk("pwr_hold", 64'(n), 64'(HOLD));
        chk_act("pwr");
        feed_lock("pwr");

        // boundary-aligned apply, cfg inputs scrambled after the snapshot
        new_cfg();
        c_mode[5:2] = 4'd9;
        c_mode[1:0] = 2'd2;
        drive_cfg();
        take_model();
        apply(1'b0);
        new_cfg();
        chk("bnd_busy", 64'(bus.busy), 64'd1);
        repeat (99) tick();
        chk("bnd_wait_drst", 64'(bus.datapath_rst_n), 64'd1);
        chk("bnd_wait_mode", 64'(bus.act_mode), 64'(DEF_MODE));
        bus.ts_head = 1'b1;
        tick();
        bus.ts_head = 1'b0;
        chk_act("bnd");
        chk("bnd_drst", 64'(bus.datapath_rst_n), 64'd0);
        chk("bnd_unlock", 64'(bus.locked), 64'd0);
        wait_drst(1'b1, 100);
        chk("bnd_hold", 64'(n), 64'(HOLD));
        feed_lock("bnd");

        // forced apply: immediate, ts_head irrelevant
        new_cfg();
        take_model();
        apply(1'b1);
        chk_act("frc");
        chk("frc_drst", 64'(bus.datapath_rst_n), 64'd0);
        bus.ts_head = 1'b1;
        wait_drst(1'b1, 100);
        bus.ts_head = 1'b0;
        chk("frc_hold", 64'(n), 64'(HOLD));
        chk("frc_busy", 64'(bus.busy), 64'd1);
        feed_lock("frc");

        // boundary watchdog
        new_cfg();
        take_model();
        apply(1'b0);
        new_cfg();
        wait_drst(1'b0, 1000);
        chk("bto_wait", 64'(n), 64'(WDOG));
        chk("bto_err", 64'(bus.err_bnd_to), 64'd1);
        chk_act("bto");
        wait_drst(1'b1, 100);
        chk("bto_hold", 64'(n), 64'(HOLD));
        feed_lock("bto");
        chk("bto_sticky", 64'(bus.err_bnd_to), 64'd1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("bto_clr", 64'(bus.err_bnd_to), 64'd0);

        // clear in the same cycle as a new timeout: set wins
        new_cfg();
        take_model();
        apply(1'b0);
        repeat (WDOG - 1) tick();
        chk("bto2_pre_drst", 64'(bus.datapath_rst_n), 64'd1);
        chk("bto2_pre_err", 64'(bus.err_bnd_to), 64'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("bto2_setwins", 64'(bus.err_bnd_to), 64'd1);
        chk("bto2_drst", 64'(bus.datapath_rst_n), 64'd0);
        wait_drst(1'b1, 100);
        feed_lock("bto2");

        // lock watchdog
        new_cfg();
        take_model();
        apply(1'b1);
        wait_drst(1'b1, 100);
        chk("lto_hold", 64'(n), 64'(HOLD));
        chk("lto_unlocked", 64'(bus.locked), 64'd0);
        repeat (WDOG - 1) tick();
        chk("lto_pre_fail", 64'(bus.fail), 64'd0);
        chk("lto_pre_busy", 64'(bus.busy), 64'd1);
        tick();
        chk("lto_fail", 64'(bus.fail), 64'd1);
        chk("lto_err", 64'(bus.err_lock_to), 64'd1);
        chk("lto_locked", 64'(bus.locked), 64'd0);
        chk("lto_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("lto_fail_pulse", 64'(bus.fail), 64'd0);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("lto_clr", 64'({bus.err_bnd_to, bus.err_lock_to}), 64'd0);

        // two requests while busy merge; launch uses cfg at IDLE time
        new_cfg();
        take_model();
        apply(1'b1);
        chk_act("pend_first");
        wait_drst(1'b1, 100);
        new_cfg();
        apply(1'b1);
        new_cfg();
        apply(1'b0);
        new_cfg();
        chk_act("pend_stable");
        feed_lock("pend_a");
        take_model();
        chk_act("pend_launch");
        chk("pend_drst", 64'(bus.datapath_rst_n), 64'd0);
        chk("pend_busy", 64'(bus.busy), 64'd1);
        wait_drst(1'b1, 100);
        chk("pend_hold", 64'(n), 64'(HOLD));
        feed_lock("pend_b");
        busy_cnt = 0;
        repeat (30) begin
            tick();
            if (bus.busy) busy_cnt++;
        end
        chk("pend_single", 64'(busy_cnt), 64'd0);

        // reset mid-hold restores defaults and drops the pending request
        new_cfg();
        take_model();
        apply(1'b1);
        chk_act("mrst_applied");
        repeat (5) tick();
        new_cfg();
        apply(1'b0);
        rst_n = 1'b0;
        tick();
        m_mode = DEF_MODE;
        m_baud = DEF_BAUD;
        m_freq = DEF_FREQ;
        chk_act("mrst");
        chk("mrst_drst", 64'(bus.datapath_rst_n), 64'd0);
        chk("mrst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b1;
        wait_drst(1'b1, 100);
        chk("mrst_hold", 64'(n), 64'(HOLD));
        chk_act("mrst_kept");
        feed_lock("mrst");
        busy_cnt = 0;
        repeat (30) begin
            tick();
            if (bus.busy) busy_cnt++;
        end
        chk("mrst_nopend", 64'(busy_cnt), 64'd0);
        chk_act("mrst_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
